// File: rtl/offnariscv_pkg.sv
// Shared ACE width constants and AR/R channel payload structs.
package offnariscv_pkg;

    localparam int unsigned ACE_ID_W     = 4;
    localparam int unsigned ACE_ADDR_W   = 32;
    localparam int unsigned ACE_DATA_W   = 64;
    localparam int unsigned ACE_USER_W   = 4;
    localparam int unsigned ACE_LEN_W    = 8;
    localparam int unsigned ACE_SIZE_W   = 3;
    localparam int unsigned ACE_BURST_W  = 2;
    localparam int unsigned ACE_CACHE_W  = 4;
    localparam int unsigned ACE_PROT_W   = 3;
    localparam int unsigned ACE_QOS_W    = 4;
    localparam int unsigned ACE_REGION_W = 4;
    localparam int unsigned ACE_SNOOP_W  = 4;
    localparam int unsigned ACE_DOMAIN_W = 2;
    localparam int unsigned ACE_BAR_W    = 2;
    localparam int unsigned ACE_RRESP_W  = 4;

    typedef struct packed {
        logic [ACE_ID_W-1:0]     id;
        logic [ACE_ADDR_W-1:0]   addr;
        logic [ACE_LEN_W-1:0]    len;
        logic [ACE_SIZE_W-1:0]   size;
        logic [ACE_BURST_W-1:0]  burst;
        logic                    lock;
        logic [ACE_CACHE_W-1:0]  cache;
        logic [ACE_PROT_W-1:0]   prot;
        logic [ACE_QOS_W-1:0]    qos;
        logic [ACE_REGION_W-1:0] region;
        logic [ACE_USER_W-1:0]   user;
        logic [ACE_SNOOP_W-1:0]  snoop;
        logic [ACE_DOMAIN_W-1:0] domain;
        logic [ACE_BAR_W-1:0]    bar;
    } ace_ar_t;

    typedef struct packed {
        logic [ACE_ID_W-1:0]    id;
        logic [ACE_DATA_W-1:0]  data;
        logic [ACE_RRESP_W-1:0] resp;
        logic                   last;
        logic [ACE_USER_W-1:0]  user;
    } ace_r_t;

endpackage

// File: rtl/ace_ar_slice.sv
// Two-entry skid buffer for the downstream AR channel; used only when
// ACE_RD_ARB_REGSLICE_EN is defined. Upstream ready is a flop (no comb path).
module ace_ar_slice
    import offnariscv_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_valid,
    output logic    o_ready,
    input  ace_ar_t i_data,
    output logic    o_valid,
    input  logic    i_ready,
    output ace_ar_t o_data
);

    logic    r_valid;
    ace_ar_t r_data;
    logic    r_skid_vld;
    ace_ar_t r_skid;

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_ready = ~r_skid_vld;

    // Main stage drains into downstream; skid catches the beat accepted while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_skid_vld <= 1'b0;
            r_skid     <= '0;
        end else if (i_ready || !r_valid) begin
            if (r_skid_vld) begin
                r_valid    <= 1'b1;
                r_data     <= r_skid;
                r_skid_vld <= 1'b0;
            end else begin
                r_valid <= i_valid;
                r_data  <= i_data;
            end
        end else if (i_valid && !r_skid_vld) begin
            r_skid     <= i_data;
            r_skid_vld <= 1'b1;
        end
    end

endmodule

// File: rtl/ace_rd_arbiter.sv
// N:1 ACE read arbiter: round-robin AR grant with per-master outstanding limit,
// id-based R routing and RACK merging. ACE_RD_ARB_REGSLICE_EN adds an AR skid buffer.
module ace_rd_arbiter
    import offnariscv_pkg::*;
#(
    parameter int unsigned NUM_MASTERS     = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_MASTERS-1:0] s_arvalid,
    output logic [NUM_MASTERS-1:0] s_arready,
    input  ace_ar_t                s_ar [NUM_MASTERS],
    output logic [NUM_MASTERS-1:0] s_rvalid,
    input  logic [NUM_MASTERS-1:0] s_rready,
    output ace_r_t                 s_r,
    input  logic [NUM_MASTERS-1:0] s_rack,
    output logic                   m_arvalid,
    input  logic                   m_arready,
    output ace_ar_t                m_ar,
    input  logic                   m_rvalid,
    output logic                   m_rready,
    input  ace_r_t                 m_r,
    output logic                   m_rack
);

    localparam int unsigned IDXW     = $clog2(NUM_MASTERS);
    localparam int unsigned CNTW     = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PENDW    = $clog2(NUM_MASTERS * MAX_OUTSTANDING + 1);
    localparam int unsigned SUMW     = PENDW + 1;
    localparam int unsigned PEND_MAX = NUM_MASTERS * MAX_OUTSTANDING;

    logic                   r_run;
    logic [IDXW-1:0]        r_rr_ptr;
    logic                   r_lock;
    logic [IDXW-1:0]        r_lock_idx;
    logic [CNTW-1:0]        r_cnt [NUM_MASTERS];
    logic [PENDW-1:0]       r_pend;

    logic [NUM_MASTERS-1:0] w_elig;
    logic [IDXW-1:0]        w_cand;
    logic                   w_sel_vld;
    logic [IDXW-1:0]        w_sel_idx;
    logic                   w_gnt_vld;
    logic [IDXW-1:0]        w_gnt_idx;
    ace_ar_t                w_gnt_ar;
    logic                   w_dn_ready;
    logic                   w_ar_hs;
    logic [IDXW-1:0]        w_r_idx;
    logic [SUMW-1:0]        w_rack_sum;
    logic [SUMW-1:0]        w_pend_nxt;

    // r_run is cleared asynchronously and keeps all comb outputs quiet in reset.
    always_comb begin
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            w_elig[i] = r_run & s_arvalid[i] & (r_cnt[i] < CNTW'(MAX_OUTSTANDING));
        end
    end

    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_idx = '0;
        w_cand    = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            w_cand = IDXW'((32'(r_rr_ptr) + k) % NUM_MASTERS);
            if (!w_sel_vld && w_elig[w_cand]) begin
                w_sel_vld = 1'b1;
                w_sel_idx = w_cand;
            end
        end
    end

    // A grant presented but not accepted is locked until its handshake.
    assign w_gnt_idx = r_lock ? r_lock_idx : w_sel_idx;
    assign w_gnt_vld = r_lock | w_sel_vld;
    assign w_ar_hs   = w_gnt_vld & w_dn_ready;

    always_comb begin
        w_gnt_ar    = s_ar[w_gnt_idx];
        w_gnt_ar.id = {w_gnt_idx, w_gnt_ar.id[ACE_ID_W-IDXW-1:0]};
        s_arready   = '0;
        if (w_ar_hs) begin
            s_arready[w_gnt_idx] = 1'b1;
        end
    end

`ifdef ACE_RD_ARB_REGSLICE_EN
    ace_ar_slice u_ar_slice (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_gnt_vld),
        .o_ready (w_dn_ready),
        .i_data  (w_gnt_ar),
        .o_valid (m_arvalid),
        .i_ready (m_arready),
        .o_data  (m_ar)
    );
`else
    assign m_arvalid  = w_gnt_vld;
    assign m_ar       = w_gnt_ar;
    assign w_dn_ready = m_arready;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else begin
            r_run      <= 1'b1;
            r_lock     <= w_gnt_vld & ~w_dn_ready;
            r_lock_idx <= w_gnt_idx;
            if (w_ar_hs) begin
                r_rr_ptr <= IDXW'((32'(w_gnt_idx) + 1) % NUM_MASTERS);
            end
        end
    end

    // R routing: ids outside the master range are drained with ready held high.
    assign w_r_idx = m_r.id[ACE_ID_W-1 -: IDXW];

    always_comb begin
        s_rvalid = '0;
        m_rready = 1'b1;
        s_r      = m_r;
        s_r.id[ACE_ID_W-1 -: IDXW] = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (w_r_idx == IDXW'(i)) begin
                s_rvalid[i] = m_rvalid & r_run;
                m_rready    = s_rready[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                case ({s_arready[i], s_rvalid[i] & s_rready[i] & m_r.last})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CNTW'(1);
                    2'b01:   if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - CNTW'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    // RACK: each pulse beyond the first in a cycle is deferred to following cycles.
    always_comb begin
        w_rack_sum = SUMW'(r_pend);
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            w_rack_sum = w_rack_sum + SUMW'(s_rack[i]);
        end
        m_rack     = r_run & (w_rack_sum != '0);
        w_pend_nxt = w_rack_sum - SUMW'(m_rack);
        if (w_pend_nxt > SUMW'(PEND_MAX)) begin
            w_pend_nxt = SUMW'(PEND_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= PENDW'(w_pend_nxt);
        end
    end

endmodule

// File: tb/tb_ace_rd_arbiter.sv
// Directed self-checking bench for ace_rd_arbiter (2 masters, 4 outstanding).
module tb_ace_rd_arbiter;
    import offnariscv_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] s_arvalid, s_arready, s_rvalid, s_rready, s_rack;
    ace_ar_t    s_ar [2];
    ace_r_t     s_r, m_r;
    ace_ar_t    m_ar;
    logic       m_arvalid, m_arready, m_rvalid, m_rready, m_rack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ace_rd_arbiter #(.NUM_MASTERS(2), .MAX_OUTSTANDING(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_ar      (s_ar),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_r       (s_r),
        .s_rack    (s_rack),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_ar      (m_ar),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_r       (m_r),
        .m_rack    (m_rack)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_arvalid = 2'b00;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        s_rready  = 2'b00;
        s_rack    = 2'b00;
        m_r       = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n     = 1'b0;
        s_arvalid = 2'b11;
        m_arready = 1'b1;
        m_rvalid  = 1'b1;
        m_r       = '0;
        m_r.id    = 4'h8;
        s_rready  = 2'b11;
        s_rack    = 2'b11;
        next_cycle();
        #4;
        checks++; if (m_arvalid !== 1'b0) begin failures++; $display("FAIL reset_m_arvalid got=%b exp=0", m_arvalid); end
        checks++; if (s_arready !== 2'b00) begin failures++; $display("FAIL reset_s_arready got=%b exp=00", s_arready); end
        checks++; if (s_rvalid !== 2'b00) begin failures++; $display("FAIL reset_s_rvalid got=%b exp=00", s_rvalid); end
        checks++; if (m_rack !== 1'b0) begin failures++; $display("FAIL reset_m_rack got=%b exp=0", m_rack); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_rdy;
        logic [3:0]  exp_id;
        logic [31:0] exp_addr;
        do_reset();
        s_arvalid = 2'b11;
        m_arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_rdy  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_id   = (k % 2 == 0) ? 4'h2 : 4'hB;
            exp_addr = (k % 2 == 0) ? 32'h1000 : 32'h2000;
            #4;
            checks++; if (m_arvalid !== 1'b1) begin failures++; $display("FAIL rr_valid k=%0d got=%b exp=1", k, m_arvalid); end
            checks++; if (s_arready !== exp_rdy) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, s_arready, exp_rdy); end
            checks++; if (m_ar.id !== exp_id) begin failures++; $display("FAIL rr_id k=%0d got=%h exp=%h", k, m_ar.id, exp_id); end
            checks++; if (m_ar.addr !== exp_addr) begin failures++; $display("FAIL rr_addr k=%0d got=%h exp=%h", k, m_ar.addr, exp_addr); end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_outstanding_limit();
        do_reset();
        s_arvalid = 2'b10;
        m_arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #4;
            checks++; if (s_arready !== 2'b10) begin failures++; $display("FAIL lim_accept k=%0d got=%b exp=10", k, s_arready); end
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            #4;
            checks++; if (s_arready !== 2'b00) begin failures++; $display("FAIL lim_stall_rdy k=%0d got=%b exp=00", k, s_arready); end
            checks++; if (m_arvalid !== 1'b0) begin failures++; $display("FAIL lim_stall_vld k=%0d got=%b exp=0", k, m_arvalid); end
            next_cycle();
        end
        m_rvalid = 1'b1;
        m_r      = '0;
        m_r.id   = 4'h9;
        m_r.last = 1'b1;
        s_rready = 2'b10;
        #4;
        checks++; if (s_rvalid !== 2'b10) begin failures++; $display("FAIL lim_r_route got=%b exp=10", s_rvalid); end
        checks++; if (m_rready !== 1'b1) begin failures++; $display("FAIL lim_r_ready got=%b exp=1", m_rready); end
        checks++; if (s_arready !== 2'b00) begin failures++; $display("FAIL lim_same_cycle got=%b exp=00", s_arready); end
        next_cycle();
        m_rvalid = 1'b0;
        s_rready = 2'b00;
        #4;
        checks++; if (s_arready !== 2'b10) begin failures++; $display("FAIL lim_resume got=%b exp=10", s_arready); end
        next_cycle();
        idle();
    endtask

    task automatic test_ar_stall();
        do_reset();
        s_arvalid = 2'b10;
        m_arready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #4;
            checks++; if (m_arvalid !== 1'b1) begin failures++; $display("FAIL stall_vld k=%0d got=%b exp=1", k, m_arvalid); end
            checks++; if (m_ar.id !== 4'hB) begin failures++; $display("FAIL stall_id k=%0d got=%h exp=b", k, m_ar.id); end
            checks++; if (s_arready !== 2'b00) begin failures++; $display("FAIL stall_rdy k=%0d got=%b exp=00", k, s_arready); end
            next_cycle();
            s_arvalid = 2'b11;
        end
        m_arready = 1'b1;
        #4;
        checks++; if (s_arready !== 2'b10) begin failures++; $display("FAIL stall_hs_rdy got=%b exp=10", s_arready); end
        checks++; if (m_ar.id !== 4'hB) begin failures++; $display("FAIL stall_hs_id got=%h exp=b", m_ar.id); end
        next_cycle();
        #4;
        checks++; if (s_arready !== 2'b01) begin failures++; $display("FAIL stall_next_rdy got=%b exp=01", s_arready); end
        checks++; if (m_ar.id !== 4'h2) begin failures++; $display("FAIL stall_next_id got=%h exp=2", m_ar.id); end
        next_cycle();
        idle();
    endtask

    task automatic test_r_route();
        logic [63:0] exp_d;
        do_reset();
        s_arvalid = 2'b10;
        m_arready = 1'b1;
        repeat (4) next_cycle();
        m_rvalid  = 1'b1;
        m_r       = '0;
        m_r.id    = 4'hD;
        s_rready  = 2'b01;
        #4;
        checks++; if (m_rready !== 1'b0) begin failures++; $display("FAIL route_bp got=%b exp=0", m_rready); end
        checks++; if (s_rvalid !== 2'b10) begin failures++; $display("FAIL route_bp_vld got=%b exp=10", s_rvalid); end
        next_cycle();
        s_rready = 2'b11;
        for (int b = 0; b < 4; b++) begin
            exp_d     = 64'hA0 + 64'(b);
            m_r.data  = exp_d;
            m_r.last  = (b == 3);
            #4;
            checks++; if (s_rvalid !== 2'b10) begin failures++; $display("FAIL route_vld b=%0d got=%b exp=10", b, s_rvalid); end
            checks++; if (s_r.id !== 4'h5) begin failures++; $display("FAIL route_id b=%0d got=%h exp=5", b, s_r.id); end
            checks++; if (s_r.data !== exp_d) begin failures++; $display("FAIL route_data b=%0d got=%h exp=%h", b, s_r.data, exp_d); end
            checks++; if (m_rready !== 1'b1) begin failures++; $display("FAIL route_rdy b=%0d got=%b exp=1", b, m_rready); end
            checks++; if (s_arready !== 2'b00) begin failures++; $display("FAIL route_cnt b=%0d got=%b exp=00", b, s_arready); end
            next_cycle();
        end
        m_rvalid = 1'b0;
        #4;
        checks++; if (s_arready !== 2'b10) begin failures++; $display("FAIL route_dec got=%b exp=10", s_arready); end
        next_cycle();
        idle();
    endtask

    task automatic test_rack();
        do_reset();
        s_rack = 2'b11;
        #4;
        checks++; if (m_rack !== 1'b1) begin failures++; $display("FAIL rack_c0 got=%b exp=1", m_rack); end
        next_cycle();
        s_rack = 2'b00;
        #4;
        checks++; if (m_rack !== 1'b1) begin failures++; $display("FAIL rack_c1 got=%b exp=1", m_rack); end
        next_cycle();
        #4;
        checks++; if (m_rack !== 1'b0) begin failures++; $display("FAIL rack_c2 got=%b exp=0", m_rack); end
        next_cycle();
        s_rack = 2'b01;
        #4;
        checks++; if (m_rack !== 1'b1) begin failures++; $display("FAIL rack_single got=%b exp=1", m_rack); end
        next_cycle();
        s_rack = 2'b00;
        #4;
        checks++; if (m_rack !== 1'b0) begin failures++; $display("FAIL rack_single_end got=%b exp=0", m_rack); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        s_arvalid = 2'b11;
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        m_r       = '0;
        m_r.id    = 4'h1;
        s_rready  = 2'b11;
        #4;
        checks++; if (m_arvalid !== 1'b1) begin failures++; $display("FAIL mid_pre_vld got=%b exp=1", m_arvalid); end
        checks++; if (s_rvalid !== 2'b01) begin failures++; $display("FAIL mid_pre_r got=%b exp=01", s_rvalid); end
        #1;
        rst_n  = 1'b0;
        s_rack = 2'b01;
        #1;
        checks++; if (m_arvalid !== 1'b0) begin failures++; $display("FAIL mid_m_arvalid got=%b exp=0", m_arvalid); end
        checks++; if (s_arready !== 2'b00) begin failures++; $display("FAIL mid_s_arready got=%b exp=00", s_arready); end
        checks++; if (s_rvalid !== 2'b00) begin failures++; $display("FAIL mid_s_rvalid got=%b exp=00", s_rvalid); end
        checks++; if (m_rack !== 1'b0) begin failures++; $display("FAIL mid_m_rack got=%b exp=0", m_rack); end
        next_cycle();
        m_rvalid  = 1'b0;
        s_rready  = 2'b00;
        s_rack    = 2'b00;
        m_arready = 1'b1;
        rst_n     = 1'b1;
        next_cycle();
        #4;
        checks++; if (s_arready !== 2'b01) begin failures++; $display("FAIL mid_first_gnt got=%b exp=01", s_arready); end
        checks++; if (m_ar.id !== 4'h2) begin failures++; $display("FAIL mid_first_id got=%h exp=2", m_ar.id); end
        next_cycle();
        idle();
    endtask

    initial begin
        s_ar[0]      = '0;
        s_ar[0].id   = 4'h2;
        s_ar[0].addr = 32'h1000;
        s_ar[1]      = '0;
        s_ar[1].id   = 4'h3;
        s_ar[1].addr = 32'h2000;
        idle();
        test_reset();
        test_round_robin();
        test_outstanding_limit();
        test_ar_stall();
        test_r_route();
        test_rack();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
